perm_pipe_ctrl: RTL and testbench
=================================

Name: perm_pipe_ctrl

Overview:
- Issue/sequencing controller for the SPU odd-pipe quadword byte-permute path.
- Accepts one byte-rotate or byte-shift instruction per cycle: rotqby, rotqbyi, shlqby or shlqbyi.
- Resolves the byte count from the immediate or from the preferred slot of RB, and performs the byte permute in the first stage.
- Carries each result through a fixed-latency valid pipeline to writeback, with writeback backpressure, flush on branch redirect, and occupancy/completion tracking.

Parameters:
- LATENCY, 4, pipeline depth in cycles from issue acceptance to wb_valid; legal range 2..8.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  instruction presented this cycle.
- issue_ready  out  1  controller can accept this cycle.
- issue_op  in  2  00=rotqby, 01=rotqbyi, 10=shlqby, 11=shlqbyi.
- issue_rt  in  7  destination register address.
- ra  in  128  source quadword; bit 0 is MSB; byte 0 = bits 0..7.
- rb  in  128  count source for register forms.
- imme7  in  7  immediate count for immediate forms.
- flush  in  1  kill all in-flight and presented work.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback port accepts the result.
- wb_rt  out  7  destination of the result.
- wb_data  out  128  permuted quadword.
- busy  out  1  any stage valid.
- inflight  out  4  number of valid stages, 0..LATENCY.
- done_count  out  CNT_W  completed writebacks; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits = 0; stage data and rt = 0; wb_valid=0, wb_rt=0, wb_data=0, busy=0, inflight=0, done_count=0. Reset in mid-operation discards all in-flight work; nothing is written back afterwards.
- Count resolution:
  - rotqbyi: s = imme7[3:6].
  - rotqby: s = rb[28:31].
  - shlqbyi: s = imme7[2:6].
  - shlqby: s = rb[27:31].
- Permute, result byte b (0..15):
  - Rotate: ra byte (b+s) mod 16; s=0 gives ra unchanged.
  - Shift: ra byte (b+s) if b+s<16, else 0x00; s>=16 gives all zero.
- Pipeline: stages 1..LATENCY, each holding valid, rt and data. The permute is computed combinationally at issue and registered into stage 1. Stage k shifts into stage k+1. wb_* are driven directly from stage LATENCY.
- Latency: an op accepted in cycle n has wb_valid=1 in cycle n+LATENCY (no stall). Throughput is one op per cycle.
- Stall = stage LATENCY valid & !wb_ready. While stalled, every stage holds (no bubble collapse) and issue_ready=0.
- issue_ready = !stall & !flush.
- Acceptance = issue_valid & issue_ready. A stage-1 bubble is inserted when nothing is accepted.
- Writeback handshake: the result retires on wb_valid & wb_ready; done_count increments on that edge. wb_valid, wb_rt and wb_data are stable while stalled.
- flush (synchronous): on the next edge all valid bits clear, including a stalled stage LATENCY. An instruction presented in the flush cycle is not accepted. A retirement in the flush cycle (wb_valid & wb_ready) still counts.
- busy = OR of valid bits. inflight = popcount of valid bits, registered-consistent with the stages.

Test Plan:
- rotqbyi, ra=0x00112233_44556677_8899AABB_CCDDEEFF, imme7=0x05, rt=9 -> in cycle n+4: wb_valid=1, wb_rt=9, wb_data=0x55667788_99AABBCC_DDEEFF00_11223344.
- shlqby with rb[27:31]=20 -> wb_data=0. shlqbyi with imme7=0x01 on the same ra -> 0x11223344_...EEFF00. rotqby with rb[28:31]=0 -> ra unchanged.
- Back-to-back: 6 ops on consecutive cycles, wb_ready=1 -> 6 consecutive wb_valid cycles in issue order; inflight peaks at 4; done_count=6.
- Backpressure: wb_ready=0 for 3 cycles while stage 4 is valid -> issue_ready=0, wb outputs frozen, no op lost or duplicated; on release, results retire one per cycle in order.
- Flush with 3 ops in flight plus one presented -> the next cycle has busy=0 and inflight=0; none of the 4 ops ever writes back; done_count is unchanged.
- Assert reset asynchronously between clock edges with 2 ops in flight -> outputs go to 0 immediately; after release, no stale wb_valid; a fresh op completes at the normal latency.

Source files
------------

// File: rtl/perm_pipe_ctrl.sv
// Issue/sequencing controller for the SPU odd-pipe quadword byte rotate/shift path.
// Permutes at issue, then carries each result through a fixed-latency valid pipeline to writeback.
module perm_pipe_ctrl #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [1:0]        issue_op,
  input  logic [6:0]        issue_rt,
  input  logic [127:0]      ra,
  input  logic [127:0]      rb,
  input  logic [6:0]        imme7,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [6:0]        wb_rt,
  output logic [127:0]      wb_data,
  output logic              busy,
  output logic [3:0]        inflight,
  output logic [CNT_W-1:0]  done_count
);

  // Architectural bit 0 is the MSB, so architectural bit i lives at vector bit 127-i.
  logic [4:0]   count;
  logic [7:0]   ra_bytes [16];
  logic [127:0] perm;

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  logic [6:0]         rt_q   [LATENCY];
  logic [127:0]       data_q [LATENCY];
  logic [3:0]         inflight_q;
  logic [CNT_W-1:0]   done_q;

  logic stall;
  logic accept;
  logic retire;
  logic unused_bits;

  assign unused_bits = ^{rb[127:101], rb[95:0], imme7[6:5]};

  always_comb begin
    count = '0;
    case (issue_op)
      2'b00:   count = {1'b0, rb[99:96]};
      2'b01:   count = {1'b0, imme7[3:0]};
      2'b10:   count = rb[100:96];
      default: count = imme7[4:0];
    endcase
  end

  always_comb begin
    for (int b = 0; b < 16; b++) begin
      ra_bytes[b] = ra[127-8*b -: 8];
    end
  end

  // Rotates wrap the byte index; shifts fill with zero once the source runs past byte 15.
  always_comb begin
    logic [5:0] pos;
    pos  = '0;
    perm = '0;
    for (int b = 0; b < 16; b++) begin
      pos = 6'(b) + {1'b0, count};
      if (!issue_op[1]) begin
        perm[127-8*b -: 8] = ra_bytes[pos[3:0]];
      end else if (pos < 6'd16) begin
        perm[127-8*b -: 8] = ra_bytes[pos[3:0]];
      end
    end
  end

  function automatic logic [3:0] count_ones(input logic [LATENCY-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < LATENCY; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  assign stall       = valid_q[LATENCY-1] & ~wb_ready;
  assign issue_ready = ~stall & ~flush;
  assign accept      = issue_valid & issue_ready;
  assign retire      = valid_q[LATENCY-1] & wb_ready;

  // A stall freezes every stage, bubbles included; flush overrides it.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (!stall) begin
      valid_d = {valid_q[LATENCY-2:0], accept};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      inflight_q <= '0;
      done_q     <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        rt_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      inflight_q <= count_ones(valid_d);
      if (retire) begin
        done_q <= done_q + CNT_W'(1);
      end
      if (!stall) begin
        rt_q[0]   <= issue_rt;
        data_q[0] <= perm;
        for (int k = 1; k < LATENCY; k++) begin
          rt_q[k]   <= rt_q[k-1];
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign wb_valid   = valid_q[LATENCY-1];
  assign wb_rt      = rt_q[LATENCY-1];
  assign wb_data    = data_q[LATENCY-1];
  assign busy       = |valid_q;
  assign inflight   = inflight_q;
  assign done_count = done_q;

endmodule

// File: tb/tb_perm_pipe_ctrl.sv
// Directed self-checking bench for perm_pipe_ctrl: permute results, latency, back-to-back,
// backpressure, flush and asynchronous reset, all against hand-computed values.
module tb_perm_pipe_ctrl;

  localparam logic [127:0] RA = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic         clk;
  logic         reset;
  logic         issue_valid;
  logic         issue_ready;
  logic [1:0]   issue_op;
  logic [6:0]   issue_rt;
  logic [127:0] ra;
  logic [127:0] rb;
  logic [6:0]   imme7;
  logic         flush;
  logic         wb_valid;
  logic         wb_ready;
  logic [6:0]   wb_rt;
  logic [127:0] wb_data;
  logic         busy;
  logic [3:0]   inflight;
  logic [15:0]  done_count;

  int checkCount;
  int passCount;

  perm_pipe_ctrl #(.LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_rt(issue_rt),
    .ra(ra), .rb(rb), .imme7(imme7), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rt(wb_rt), .wb_data(wb_data),
    .busy(busy), .inflight(inflight), .done_count(done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [6:0] rt,
                               input logic [127:0] rbv, input logic [6:0] imm);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rt    = rt;
    rb          = rbv;
    imme7       = imm;
  endtask

  task automatic idleIssue();
    issue_valid = 1'b0;
  endtask

  // Back-to-back vectors: rotqbyi, shlqby, shlqbyi, rotqby, rotqby, shlqby.
  logic [1:0]   b2bOp   [6];
  logic [6:0]   b2bRt   [6];
  logic [127:0] b2bRb   [6];
  logic [6:0]   b2bImm  [6];
  logic [127:0] b2bData [6];
  logic [3:0]   b2bInflight [11];
  logic [6:0]   bpRt   [5];
  logic [6:0]   bpImm  [5];
  logic [127:0] bpData [5];
  logic [3:0]   peak;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    peak       = '0;

    b2bOp   = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10};
    b2bRt   = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6};
    b2bRb   = '{128'hF << 96, (128'd20 << 96) | (128'h1 << 101), '1,
                128'h1 << 100, 128'd3 << 96, 128'd3 << 96};
    b2bImm  = '{7'h15, 7'h7F, 7'h01, 7'h7F, 7'h00, 7'h00};
    b2bData = '{128'h55667788_99AABBCC_DDEEFF00_11223344,
                128'h0,
                128'h11223344_55667788_99AABBCC_DDEEFF00,
                128'h00112233_44556677_8899AABB_CCDDEEFF,
                128'h33445566_778899AA_BBCCDDEE_FF001122,
                128'h33445566_778899AA_BBCCDDEE_FF000000};
    b2bInflight = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

    bpRt   = '{7'd11, 7'd12, 7'd13, 7'd14, 7'd15};
    bpImm  = '{7'd0, 7'd2, 7'd8, 7'd15, 7'd4};
    bpData = '{128'h00112233_44556677_8899AABB_CCDDEEFF,
               128'h22334455_66778899_AABBCCDD_EEFF0011,
               128'h8899AABB_CCDDEEFF_00112233_44556677,
               128'hFF001122_33445566_778899AA_BBCCDDEE,
               128'h44556677_8899AABB_CCDDEEFF_00112233};

    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_op    = '0;
    issue_rt    = '0;
    ra          = RA;
    rb          = '0;
    imme7       = '0;
    flush       = 1'b0;
    wb_ready    = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_wb_rt", wb_rt, 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_inflight", inflight, 0);
    checkOutput("rst_done", done_count, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", issue_ready, 1);

    // Single rotqbyi, latency 4.
    applyStimulus(2'b01, 7'd9, '0, 7'h05);
    @(negedge clk);
    idleIssue();
    checkOutput("single_inflight", inflight, 1);
    checkOutput("single_busy", busy, 1);
    repeat (2) @(negedge clk);
    checkOutput("single_early_valid", wb_valid, 0);
    @(negedge clk);
    checkOutput("single_wb_valid", wb_valid, 1);
    checkOutput("single_wb_rt", wb_rt, 9);
    checkOutput("single_wb_data", wb_data, 128'h55667788_99AABBCC_DDEEFF00_11223344);
    @(negedge clk);
    checkOutput("single_done", done_count, 1);
    checkOutput("single_idle_busy", busy, 0);
    checkOutput("single_after_valid", wb_valid, 0);

    // Six ops on consecutive cycles.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_inflight_%0d", i), inflight, b2bInflight[i]);
      if (inflight > peak) peak = inflight;
      if (i >= 4 && i <= 9) begin
        checkOutput($sformatf("b2b_wb_valid_%0d", i), wb_valid, 1);
        checkOutput($sformatf("b2b_wb_rt_%0d", i), wb_rt, b2bRt[i-4]);
        checkOutput($sformatf("b2b_wb_data_%0d", i), wb_data, b2bData[i-4]);
      end else begin
        checkOutput($sformatf("b2b_wb_idle_%0d", i), wb_valid, 0);
      end
      if (i < 6) applyStimulus(b2bOp[i], b2bRt[i], b2bRb[i], b2bImm[i]);
      else idleIssue();
    end
    checkOutput("b2b_peak_inflight", peak, 4);
    checkOutput("b2b_done", done_count, 7);

    // Backpressure: hold wb_ready low for three edges with stage 4 valid.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(2'b01, bpRt[i], '0, bpImm[i]);
    end
    @(negedge clk);
    wb_ready = 1'b0;
    applyStimulus(2'b01, bpRt[4], '0, bpImm[4]);
    #1;
    checkOutput("bp_ready_low", issue_ready, 0);
    checkOutput("bp_wb_rt_first", wb_rt, bpRt[0]);
    checkOutput("bp_inflight", inflight, 4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_hold_valid_%0d", i), wb_valid, 1);
      checkOutput($sformatf("bp_hold_rt_%0d", i), wb_rt, bpRt[0]);
      checkOutput($sformatf("bp_hold_data_%0d", i), wb_data, bpData[0]);
      checkOutput($sformatf("bp_hold_ready_%0d", i), issue_ready, 0);
      checkOutput($sformatf("bp_hold_inflight_%0d", i), inflight, 4);
    end
    @(negedge clk);
    wb_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", issue_ready, 1);
    checkOutput("bp_release_rt", wb_rt, bpRt[0]);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      idleIssue();
      checkOutput($sformatf("bp_drain_valid_%0d", i), wb_valid, 1);
      checkOutput($sformatf("bp_drain_rt_%0d", i), wb_rt, bpRt[i]);
      checkOutput($sformatf("bp_drain_data_%0d", i), wb_data, bpData[i]);
    end
    @(negedge clk);
    checkOutput("bp_empty", wb_valid, 0);
    checkOutput("bp_done", done_count, 12);

    // Flush with three in flight and one presented.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(2'b00, 7'(21 + i), '0, '0);
    end
    @(negedge clk);
    applyStimulus(2'b00, 7'd24, '0, '0);
    flush = 1'b1;
    #1;
    checkOutput("flush_ready", issue_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    idleIssue();
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_inflight", inflight, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("flush_no_wb_%0d", i), wb_valid, 0);
    end
    checkOutput("flush_done", done_count, 12);

    // Asynchronous reset between edges with two ops in flight.
    @(negedge clk);
    applyStimulus(2'b01, 7'd31, '0, 7'h01);
    @(negedge clk);
    applyStimulus(2'b01, 7'd32, '0, 7'h02);
    @(negedge clk);
    idleIssue();
    checkOutput("pre_reset_inflight", inflight, 2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_inflight", inflight, 0);
    checkOutput("async_rst_wb_valid", wb_valid, 0);
    checkOutput("async_rst_wb_data", wb_data, 0);
    checkOutput("async_rst_done", done_count, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_no_wb_%0d", i), wb_valid, 0);
    end
    applyStimulus(2'b01, 7'd40, '0, 7'h05);
    @(negedge clk);
    idleIssue();
    repeat (2) @(negedge clk);
    checkOutput("post_rst_early", wb_valid, 0);
    @(negedge clk);
    checkOutput("post_rst_wb_valid", wb_valid, 1);
    checkOutput("post_rst_wb_rt", wb_rt, 40);
    checkOutput("post_rst_wb_data", wb_data, 128'h55667788_99AABBCC_DDEEFF00_11223344);
    @(negedge clk);
    checkOutput("post_rst_done", done_count, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
